// File: rtl/ysyx_22040237_gpr_bank.sv
// Parametrised GPR bank: two write-back lanes, N read ports, per-register busy scoreboard.
// Optional same-cycle write-to-read bypass enabled by defining YSYX_22040237_GPR_BYPASS_EN.
module ysyx_22040237_gpr_bank #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned AW       = 5,
    parameter int unsigned RD_PORTS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb0_en,
    input  logic [AW-1:0]            wb0_addr,
    input  logic [XLEN-1:0]          wb0_data,
    input  logic                     wb1_en,
    input  logic [AW-1:0]            wb1_addr,
    input  logic [XLEN-1:0]          wb1_data,
    input  logic [RD_PORTS-1:0]      rd_en,
    input  logic [RD_PORTS*AW-1:0]   rd_addr,
    output logic [RD_PORTS*XLEN-1:0] rd_data,
    output logic [RD_PORTS-1:0]      rd_busy,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    input  logic                     flush,
    output logic                     sb_empty
);

    localparam int unsigned NREG = 2 ** AW;

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d, set_cnt, clr_cnt;
    logic            sb_empty_q;

    logic wb0_wr, wb1_wr, iss_set;

    assign wb0_wr  = wb0_en && (wb0_addr != '0);
    assign wb1_wr  = wb1_en && (wb1_addr != '0);
    assign iss_set = iss_en && (iss_addr != '0);

    // Clears apply first so a same-cycle issue (the newer producer) keeps its bit set.
    always_comb begin
        busy_d = flush ? '0 : busy_q;
        if (wb0_wr) busy_d[wb0_addr] = 1'b0;
        if (wb1_wr) busy_d[wb1_addr] = 1'b0;
        if (iss_set) busy_d[iss_addr] = 1'b1;
    end

    always_comb begin
        set_cnt = '0;
        clr_cnt = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            set_cnt = set_cnt + {{AW{1'b0}}, busy_d[i] & ~busy_q[i]};
            clr_cnt = clr_cnt + {{AW{1'b0}}, busy_q[i] & ~busy_d[i]};
        end
        cnt_d = cnt_q + set_cnt - clr_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            cnt_q      <= '0;
            sb_empty_q <= 1'b1;
        end else begin
            // Lane 1 is younger, so its write lands last on an address collision.
            if (wb0_wr) regs_q[wb0_addr] <= wb0_data;
            if (wb1_wr) regs_q[wb1_addr] <= wb1_data;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            sb_empty_q <= (cnt_d == '0);
        end
    end

    assign sb_empty = sb_empty_q;

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] data;
        logic            busy;

        assign ra = rd_addr[p*AW +: AW];

        always_comb begin
            data = regs_q[ra];
            busy = busy_q[ra];
`ifdef YSYX_22040237_GPR_BYPASS_EN
            if (wb1_wr && (wb1_addr == ra)) begin
                data = wb1_data;
                busy = iss_set && (iss_addr == ra);
            end else if (wb0_wr && (wb0_addr == ra)) begin
                data = wb0_data;
                busy = iss_set && (iss_addr == ra);
            end
`endif
            if (!rd_en[p]) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = data;
        assign rd_busy[p]              = busy;
    end

endmodule

// File: tb/tb_ysyx_22040237_gpr_bank.sv
// Directed self-checking bench for ysyx_22040237_gpr_bank (default XLEN=64, AW=5, two read ports).
module tb_ysyx_22040237_gpr_bank;

    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 5;
    localparam int unsigned RP   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb0_en, wb1_en, iss_en, flush;
    logic [AW-1:0]     wb0_addr, wb1_addr, iss_addr;
    logic [XLEN-1:0]   wb0_data, wb1_data;
    logic [RP-1:0]     rd_en;
    logic [RP*AW-1:0]  rd_addr;
    logic [RP*XLEN-1:0] rd_data;
    logic [RP-1:0]     rd_busy;
    logic              sb_empty;

    int errors = 0;
    int checks = 0;

    ysyx_22040237_gpr_bank #(.XLEN(XLEN), .AW(AW), .RD_PORTS(RP)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb0_en   (wb0_en),
        .wb0_addr (wb0_addr),
        .wb0_data (wb0_data),
        .wb1_en   (wb1_en),
        .wb1_addr (wb1_addr),
        .wb1_data (wb1_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .sb_empty (sb_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb0_en = 0; wb1_en = 0; iss_en = 0; flush = 0;
        wb0_addr = '0; wb1_addr = '0; iss_addr = '0;
        wb0_data = '0; wb1_data = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en   = 2'b11;
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        rd_en = 2'b11; rd_addr = '0;
        rst = 1'b1;
        tick();
        chk("reset_sb_empty", {63'd0, sb_empty}, 64'd1);
        chk("reset_rd_busy", {62'd0, rd_busy}, 64'd0);
        rst = 1'b0;
        tick();

        // x5 written, x6 issued, then asynchronous reset mid-cycle
        wb0_en = 1; wb0_addr = 5'd5; wb0_data = 64'h1234;
        iss_en = 1; iss_addr = 5'd6;
        tick();
        idle();
        rd(5'd5, 5'd6);
        chk("pre_rst_x5", rd_data[63:0], 64'h1234);
        chk("pre_rst_x6_busy", {62'd0, rd_busy}, 64'd2);
        chk("pre_rst_sb_empty", {63'd0, sb_empty}, 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_x5_data", rd_data[63:0], 64'd0);
        chk("rst_rd_busy", {62'd0, rd_busy}, 64'd0);
        chk("rst_sb_empty", {63'd0, sb_empty}, 64'd1);
        rst = 1'b0;
        tick();

        // x0 protection
        wb0_en = 1; wb0_addr = 5'd0; wb0_data = 64'hFFFF;
        iss_en = 1; iss_addr = 5'd0;
        tick();
        idle();
        rd(5'd0, 5'd0);
        chk("x0_data", rd_data[63:0], 64'd0);
        chk("x0_busy", {62'd0, rd_busy}, 64'd0);
        chk("x0_sb_empty", {63'd0, sb_empty}, 64'd1);

        // dual-lane collision
        wb0_en = 1; wb0_addr = 5'd7; wb0_data = 64'hAAAA;
        wb1_en = 1; wb1_addr = 5'd7; wb1_data = 64'h5555;
        tick();
        idle();
        rd(5'd7, 5'd7);
        chk("collision_x7", rd_data[127:64], 64'h5555);
        rd_en = 2'b10;
        #1;
        chk("rd_en0_data", rd_data[63:0], 64'd0);

        // scoreboard lifecycle on x3
        iss_en = 1; iss_addr = 5'd3;
        tick();
        idle();
        rd(5'd3, 5'd0);
        chk("iss_x3_busy", {62'd0, rd_busy}, 64'd1);
        chk("iss_x3_sb_empty", {63'd0, sb_empty}, 64'd0);
        rd_en = 2'b00;
        wb0_en = 1; wb0_addr = 5'd3; wb0_data = 64'h42;
        tick();
        idle();
        rd(5'd3, 5'd0);
        chk("wb_x3_busy", {62'd0, rd_busy}, 64'd0);
        chk("wb_x3_data", rd_data[63:0], 64'h42);
        chk("wb_x3_sb_empty", {63'd0, sb_empty}, 64'd1);
        rd_en = 2'b00;
        iss_en = 1; iss_addr = 5'd3;
        wb1_en = 1; wb1_addr = 5'd3; wb1_data = 64'h43;
        tick();
        idle();
        rd(5'd3, 5'd0);
        chk("iss_wb_x3_busy", {62'd0, rd_busy}, 64'd1);
        chk("iss_wb_x3_data", rd_data[63:0], 64'h43);
        chk("iss_wb_sb_empty", {63'd0, sb_empty}, 64'd0);
        rd_en = 2'b00;
        wb0_en = 1; wb0_addr = 5'd3; wb0_data = 64'h44;
        tick();
        idle();
        chk("x3_retired_sb_empty", {63'd0, sb_empty}, 64'd1);

        // flush with issue; write in the flush cycle still lands
        iss_en = 1; iss_addr = 5'd1; tick();
        iss_addr = 5'd2; tick();
        iss_addr = 5'd4; tick();
        idle();
        chk("three_busy_sb_empty", {63'd0, sb_empty}, 64'd0);
        flush = 1; iss_en = 1; iss_addr = 5'd9;
        wb1_en = 1; wb1_addr = 5'd11; wb1_data = 64'h77;
        tick();
        idle();
        rd(5'd1, 5'd2);
        chk("flush_x1_x2_busy", {62'd0, rd_busy}, 64'd0);
        rd(5'd4, 5'd9);
        chk("flush_x4_x9_busy", {62'd0, rd_busy}, 64'd2);
        chk("flush_sb_empty", {63'd0, sb_empty}, 64'd0);
        rd(5'd11, 5'd0);
        chk("flush_wb_x11", rd_data[63:0], 64'h77);
        rd_en = 2'b00;
        wb0_en = 1; wb0_addr = 5'd9; wb0_data = 64'h9;
        tick();
        idle();
        chk("count_one_sb_empty", {63'd0, sb_empty}, 64'd1);

        // bypass of busy x10 on port 1
        iss_en = 1; iss_addr = 5'd10;
        tick();
        idle();
        wb1_en = 1; wb1_addr = 5'd10; wb1_data = 64'hBEEF;
        rd(5'd0, 5'd10);
`ifdef YSYX_22040237_GPR_BYPASS_EN
        chk("bypass_data", rd_data[127:64], 64'hBEEF);
        chk("bypass_busy", {62'd0, rd_busy}, 64'd0);
`else
        chk("nobypass_data", rd_data[127:64], 64'd0);
        chk("nobypass_busy", {62'd0, rd_busy}, 64'd2);
`endif
        tick();
        idle();
        #1;
        chk("x10_after_data", rd_data[127:64], 64'hBEEF);
        chk("x10_after_busy", {62'd0, rd_busy}, 64'd0);
        chk("x10_after_sb_empty", {63'd0, sb_empty}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040237_gpr_bank.md
Name: ysyx_22040237_gpr_bank

Overview:
- Parametrised general-purpose register bank for the pipelined core.
- Replaces the single-cycle register file.
- Adds configurable width, depth and read-port count, two write-back ports, a per-register busy scoreboard and optional write-to-read bypass.
- Sits between decode/issue (reads, busy marking) and write-back (two retire lanes).

Parameters:
XLEN, 64, data width of each register
AW, 5, register address width; register count NREG = 2**AW
RD_PORTS, 2, number of independent read ports (1..4)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-high reset
wb0_en  input  1  write-back lane 0 valid (older instruction)
wb0_addr  input  AW  lane 0 destination register
wb0_data  input  XLEN  lane 0 write data
wb1_en  input  1  write-back lane 1 valid (younger instruction)
wb1_addr  input  AW  lane 1 destination register
wb1_data  input  XLEN  lane 1 write data
rd_en  input  RD_PORTS  per-port read enable
rd_addr  input  RD_PORTS*AW  read addresses; port i occupies bits [i*AW +: AW]
rd_data  output  RD_PORTS*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
rd_busy  output  RD_PORTS  per-port: source register has a pending producer
iss_en  input  1  issue valid: mark iss_addr busy
iss_addr  input  AW  destination register of the issuing instruction
flush  input  1  pipeline flush: clear all busy bits
sb_empty  output  1  high when no register is busy

Behaviour:
- Reset (asynchronous, rst=1):
  - all NREG registers cleared to 0 immediately;
  - all busy bits cleared;
  - outstanding counter cleared;
  - sb_empty=1.
  - Deassertion takes effect at the next edge; rst mid-operation discards pending writes and issues.
- Register 0 is hardwired zero:
  - writes to address 0 are dropped on both lanes;
  - iss_addr=0 never sets busy;
  - reads of address 0 return 0 with rd_busy=0.
- Writes take effect at the rising edge when wbN_en=1 and wbN_addr!=0.
  - Both lanes to the same address: lane 1 data is stored.
- Reads are combinational.
  - rd_en[i]=0: rd_data port i = 0 and rd_busy[i] = 0.
  - rd_en[i]=1: rd_data port i = stored register value, subject to bypass (see Optional Feature).
- Scoreboard: one busy bit per register, updated at the rising edge.
  - Set: iss_en=1 and iss_addr!=0.
  - Clear: a write-back lane writes that address, or flush=1.
  - Same-cycle issue and write-back to the same address: busy stays set, because the new producer supersedes the old.
  - flush=1 together with iss_en=1: flush clears everything, then the issue sets its bit. Result: only iss_addr is busy.
  - flush does not block register writes in the same cycle.
- Outstanding counter: AW+1 bits, equal to the population count of the busy bits.
  - Maintained incrementally: +1 on a newly set bit, -1 per newly cleared bit.
  - A write-back to a non-busy register does not decrement; saturation at 0 is never needed.
  - Reaches NREG-1 at most.
  - sb_empty = (counter == 0), registered.
- rd_busy[i] = busy[rd_addr_i], modified by bypass as below.

Optional Feature:
- Macro YSYX_22040237_GPR_BYPASS_EN.
- Defined:
  - a read whose address matches an enabled, nonzero write-back lane in the same cycle returns that lane's wb data; lane 1 has priority over lane 0;
  - rd_busy for that port is forced to 0 in that cycle, unless iss_en targets the same address in that cycle.
- Not defined:
  - reads return the stored value only;
  - new data is visible one cycle after the write edge;
  - rd_busy stays at the busy bit until the edge that clears it.

Test Plan:
- Reset values: assert rst asynchronously mid-cycle after writing x5=0x1234 -> rd_data for x5 = 0 immediately; sb_empty=1; all rd_busy=0.
- x0 protection: wb0 writes x0=0xFFFF, issue x0 -> read x0 = 0, rd_busy=0, sb_empty stays 1.
- Dual-lane collision: wb0 x7=0xAAAA and wb1 x7=0x5555 in the same cycle -> next cycle read x7 = 0x5555.
- Scoreboard lifecycle:
  - issue x3 -> next cycle rd_busy=1, sb_empty=0.
  - wb0 x3=0x42 -> next cycle rd_busy=0, data 0x42, sb_empty=1.
  - Issue and wb x3 in the same cycle -> x3 remains busy.
- Flush with issue: x1, x2, x4 busy; flush=1 with iss x9 -> only x9 busy, counter=1.
- Bypass: wb1 x10=0xBEEF while port 1 reads busy x10.
  - With macro: rd_data=0xBEEF, rd_busy=0 in the same cycle.
  - Without macro: old value, rd_busy=1; 0xBEEF visible next cycle.
